// File: rtl/aha_clock_select_controller_pkg.sv
// Shared definitions for the clock-select sequencer.
//   state_e                : FSM state encoding (IDLE=0, DROP=1, RAISE=2, ERROR=3)
//   DEFAULT_TIMEOUT_CYCLES : default bound on any wait state, in CLK cycles
//   sel_id_width()         : width of the command index field
package aha_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DROP  = 2'd1,
    ST_RAISE = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

  // The command index carries one bit more than a slice index so that an
  // out-of-range request is representable (and rejectable) for every NUM_CLKS.
  function automatic int sel_id_width(input int num_clks);
    return $clog2(num_clks) + 1;
  endfunction

endpackage

// File: rtl/aha_clock_select_controller_if.sv
// Command / slice handshake bundle of the clock-select sequencer.
//   SEL_VALID, SEL_ID, SEL_READY  : select command handshake
//   SELECT_REQ, SELECT_ACK        : per-slice request / acknowledge
//   CURRENT_SEL, SWITCH_DONE      : status of the last completed switch
//   SWITCH_ERROR, ERROR_CLEAR     : sticky error flag and its clear
// master = command issuer + slice side, slave = the controller.
interface aha_clock_select_controller_if #(
  parameter int NUM_CLKS = 4
);
  import aha_clk_ctrl_pkg::*;

  localparam int ID_W  = sel_id_width(NUM_CLKS);
  localparam int CUR_W = $clog2(NUM_CLKS);

  logic                SEL_VALID;
  logic [ID_W-1:0]     SEL_ID;
  logic                SEL_READY;
  logic [NUM_CLKS-1:0] SELECT_REQ;
  logic [NUM_CLKS-1:0] SELECT_ACK;
  logic [CUR_W-1:0]    CURRENT_SEL;
  logic                SWITCH_DONE;
  logic                SWITCH_ERROR;
  logic                ERROR_CLEAR;

  modport master (
    output SEL_VALID, SEL_ID, SELECT_ACK, ERROR_CLEAR,
    input  SEL_READY, SELECT_REQ, CURRENT_SEL, SWITCH_DONE, SWITCH_ERROR
  );

  modport slave (
    input  SEL_VALID, SEL_ID, SELECT_ACK, ERROR_CLEAR,
    output SEL_READY, SELECT_REQ, CURRENT_SEL, SWITCH_DONE, SWITCH_ERROR
  );

endinterface

// File: rtl/aha_clock_select_controller_sync_bit.sv
// Two-flop synchronizer bringing one slice acknowledge into the CLK domain.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronized output, two clk edges behind d
module AhaSyncBit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture; the first stage may go metastable and is never used directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/aha_clock_select_controller.sv
// Break-before-make sequencer for the per-clock glitch-free switch slices.
//   CLK   : always-on reference clock
//   RESET : asynchronous active-high reset
//   bus   : command handshake, per-slice request/acknowledge, status and
//           error flag (see aha_clock_select_controller_if)
// A switch drops every request, waits for all synchronized acknowledges to
// fall, raises the target request and waits for its acknowledge. Both waits
// are bounded by TIMEOUT_CYCLES; expiry parks the FSM in ERROR.
module aha_clock_select_controller
  import aha_clk_ctrl_pkg::*;
#(
  parameter int NUM_CLKS       = 4,
  parameter int DEFAULT_SEL    = 0,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic CLK,
  input  logic RESET,
  aha_clock_select_controller_if.slave bus
);

  localparam int ID_W  = sel_id_width(NUM_CLKS);
  localparam int CUR_W = $clog2(NUM_CLKS);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_DROP  = ST_DROP;
  localparam logic [1:0] S_RAISE = ST_RAISE;
  localparam logic [1:0] S_ERROR = ST_ERROR;

  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [NUM_CLKS-1:0] REQ_ONE   = NUM_CLKS'(1);
  localparam logic [NUM_CLKS-1:0] REQ_RESET = REQ_ONE << DEFAULT_SEL;
  localparam logic [CUR_W-1:0]    CUR_RESET = CUR_W'(DEFAULT_SEL);
  localparam logic [ID_W-1:0]     ID_LIMIT  = ID_W'(NUM_CLKS);

  logic [NUM_CLKS-1:0] ack_s;

  logic [1:0]          state_r,  state_next;
  logic [NUM_CLKS-1:0] req_r,    req_next;
  logic [CUR_W-1:0]    cur_r,    cur_next;
  logic [CUR_W-1:0]    tgt_r,    tgt_next;
  logic [CNT_W-1:0]    cnt_r,    cnt_next;
  logic                done_r,   done_next;
  logic                err_r,    err_next;
  logic                ready_r,  ready_next;
  logic                err_set_s;
  logic [CNT_W-1:0]    cnt_step_s;

  for (genvar i = 0; i < NUM_CLKS; i++) begin : g_ack_sync
    AhaSyncBit u_sync (
      .clk (CLK),
      .rst (RESET),
      .d   (bus.SELECT_ACK[i]),
      .q   (ack_s[i])
    );
  end

  // Saturating wait counter value for the coming edge.
  always_comb begin
    if (cnt_r == CNT_MAX) begin
      cnt_step_s = cnt_r;
    end else begin
      cnt_step_s = cnt_r + CNT_W'(1);
    end
  end

  // Next-state and datapath decisions of the switch sequencer.
  always_comb begin
    state_next = state_r;
    req_next   = req_r;
    cur_next   = cur_r;
    tgt_next   = tgt_r;
    cnt_next   = cnt_r;
    done_next  = 1'b0;
    err_set_s  = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (bus.SEL_VALID && ready_r) begin
          if (bus.SEL_ID >= ID_LIMIT) begin
            err_set_s = 1'b1;
          end else if (bus.SEL_ID[CUR_W-1:0] == cur_r) begin
            done_next = 1'b1;
          end else begin
            tgt_next   = bus.SEL_ID[CUR_W-1:0];
            req_next   = '0;
            cnt_next   = '0;
            state_next = S_DROP;
          end
        end else begin
          state_next = S_IDLE;
        end
      end

      // Every slice must be off, not just the previous one, before any raise.
      S_DROP: begin
        if (ack_s == '0) begin
          req_next   = REQ_ONE << tgt_r;
          cnt_next   = '0;
          state_next = S_RAISE;
        end else begin
          cnt_next = cnt_step_s;
          if (cnt_step_s == CNT_MAX) begin
            err_set_s  = 1'b1;
            state_next = S_ERROR;
          end else begin
            state_next = S_DROP;
          end
        end
      end

      S_RAISE: begin
        if (ack_s[tgt_r]) begin
          cur_next   = tgt_r;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_step_s;
          if (cnt_step_s == CNT_MAX) begin
            err_set_s  = 1'b1;
            state_next = S_ERROR;
          end else begin
            state_next = S_RAISE;
          end
        end
      end

      // Requests are left as they were so the command can simply be reissued.
      S_ERROR: begin
        if (bus.ERROR_CLEAR) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_ERROR;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // A new error outranks a simultaneous clear.
    if (err_set_s) begin
      err_next = 1'b1;
    end else if (bus.ERROR_CLEAR) begin
      err_next = 1'b0;
    end else begin
      err_next = err_r;
    end

    ready_next = (state_next == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= S_IDLE;
      req_r   <= REQ_RESET;
      cur_r   <= CUR_RESET;
      tgt_r   <= CUR_RESET;
      cnt_r   <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_next;
      req_r   <= req_next;
      cur_r   <= cur_next;
      tgt_r   <= tgt_next;
      cnt_r   <= cnt_next;
      done_r  <= done_next;
      err_r   <= err_next;
      ready_r <= ready_next;
    end
  end

  assign bus.SEL_READY    = ready_r;
  assign bus.SELECT_REQ   = req_r;
  assign bus.CURRENT_SEL  = cur_r;
  assign bus.SWITCH_DONE  = done_r;
  assign bus.SWITCH_ERROR = err_r;

endmodule

// File: tb/tb_aha_clock_select_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then a
// randomized phase; a reference model of the switching rules is compared
// against every output on each falling clock edge.
module tb_aha_clock_select_controller;

  localparam int NC = 4;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  aha_clock_select_controller_if #(.NUM_CLKS(NC)) bus ();

  aha_clock_select_controller #(
    .NUM_CLKS       (NC),
    .DEFAULT_SEL    (0),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int WAIT_NONE      = 0;  // idle, taking commands
  localparam int WAIT_ALL_OFF   = 1;  // waiting for every acknowledge to be low
  localparam int WAIT_TARGET_ON = 2;  // waiting for the target acknowledge
  localparam int HALTED         = 3;  // timed out, waiting for a clear

  int         m_mode, m_cur, m_tgt, m_wait;
  logic [3:0] m_req, m_s1, m_s2, seen;
  bit         m_done, m_err, set_err;

  task automatic model_reset();
    m_mode = WAIT_NONE; m_cur = 0; m_tgt = 0; m_wait = 0;
    m_req = 4'b0001; m_s1 = 4'b0000; m_s2 = 4'b0000;
    m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = bus.SELECT_ACK;
    m_done = 1'b0;
    set_err = 1'b0;
    if (m_mode == WAIT_NONE) begin
      if (bus.SEL_VALID) begin
        if (int'(bus.SEL_ID) >= NC) set_err = 1'b1;
        else if (int'(bus.SEL_ID) == m_cur) m_done = 1'b1;
        else begin
          m_tgt = int'(bus.SEL_ID); m_req = 4'b0000; m_mode = WAIT_ALL_OFF; m_wait = 0;
        end
      end
    end else if (m_mode == WAIT_ALL_OFF || m_mode == WAIT_TARGET_ON) begin
      if (m_mode == WAIT_ALL_OFF && seen == 4'b0000) begin
        m_req = 4'b0001 << m_tgt; m_mode = WAIT_TARGET_ON; m_wait = 0;
      end else if (m_mode == WAIT_TARGET_ON && seen[m_tgt]) begin
        m_cur = m_tgt; m_done = 1'b1; m_mode = WAIT_NONE;
      end else begin
        m_wait++;
        if (m_wait >= TO) begin m_mode = HALTED; set_err = 1'b1; end
      end
    end else begin
      if (bus.ERROR_CLEAR) m_mode = WAIT_NONE;
    end
    if (set_err) m_err = 1'b1;
    else if (bus.ERROR_CLEAR) m_err = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("req",   bus.SELECT_REQ,   m_req);
        check("cur",   bus.CURRENT_SEL,  m_cur);
        check("done",  bus.SWITCH_DONE,  m_done);
        check("err",   bus.SWITCH_ERROR, m_err);
        check("ready", bus.SEL_READY,    m_mode == WAIT_NONE);
      end
    end
  end

  // ---------------- slice acknowledge environment ----------------
  logic [3:0] hist [0:7];
  int         dly = 0;
  logic [3:0] stuck_on  = 4'b0000;
  logic [3:0] stuck_off = 4'b0000;

  // Advance to just after the next falling edge and refresh the acknowledges.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = bus.SELECT_REQ;
    bus.SELECT_ACK = (hist[dly] | stuck_on) & ~stuck_off;
  endtask

  // Issue a command and time when the target request rises and SWITCH_DONE pulses.
  task automatic switch_timed(input int id, output int t_on, output int t_done, output int n_done);
    bus.SEL_VALID = 1'b1;
    bus.SEL_ID = 3'(id);
    t_on = -1; t_done = -1; n_done = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      bus.SEL_VALID = 1'b0;
      if (t_on < 0 && bus.SELECT_REQ[id]) t_on = k;
      if (bus.SWITCH_DONE) begin
        n_done++;
        if (t_done < 0) t_done = k;
      end
      if (t_done >= 0 && k >= t_done + 3) break;
    end
  endtask

  int t_on, t_done, n_done, n_raise, stuck_left;

  initial begin
    for (int i = 0; i < 8; i++) hist[i] = 4'b0000;
    bus.SEL_VALID = 1'b0; bus.SEL_ID = 3'd0; bus.ERROR_CLEAR = 1'b0; bus.SELECT_ACK = 4'b0000;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_req",   bus.SELECT_REQ,   4'b0001);
    check("reset_cur",   bus.CURRENT_SEL,  2'd0);
    check("reset_ready", bus.SEL_READY,    1'b1);
    check("reset_err",   bus.SWITCH_ERROR, 1'b0);
    repeat (4) tick();

    // Ideal acknowledges: request rises on cycle 4, done on cycle 7.
    switch_timed(1, t_on, t_done, n_done);
    check("ideal_req_on", t_on,   4);
    check("ideal_done",   t_done, 7);
    check("ideal_cur",    bus.CURRENT_SEL, 2'd1);

    // Five-cycle acknowledge delay.
    dly = 5;
    repeat (8) tick();
    switch_timed(2, t_on, t_done, n_done);
    check("dly5_req_on", t_on,   9);
    check("dly5_done",   t_done, 17);
    check("dly5_pulses", n_done, 1);
    check("dly5_req",    bus.SELECT_REQ,  4'b0100);
    check("dly5_cur",    bus.CURRENT_SEL, 2'd2);

    // Same slice: done one cycle after accept, requests untouched.
    switch_timed(2, t_on, t_done, n_done);
    check("same_done",   t_done, 1);
    check("same_pulses", n_done, 1);
    check("same_req",    bus.SELECT_REQ, 4'b0100);

    // Out-of-range index.
    bus.SEL_VALID = 1'b1; bus.SEL_ID = 3'd5;
    tick();
    bus.SEL_VALID = 1'b0;
    check("inval_err",   bus.SWITCH_ERROR, 1'b1);
    check("inval_ready", bus.SEL_READY,    1'b1);
    check("inval_req",   bus.SELECT_REQ,   4'b0100);
    bus.ERROR_CLEAR = 1'b1;
    tick();
    bus.ERROR_CLEAR = 1'b0;
    check("inval_clear", bus.SWITCH_ERROR, 1'b0);

    // Target never acknowledges: 20 cycles in the raise wait, then error.
    dly = 0;
    repeat (8) tick();
    stuck_off = 4'b1000;
    bus.SEL_VALID = 1'b1; bus.SEL_ID = 3'd3;
    n_raise = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      bus.SEL_VALID = 1'b0;
      if (bus.SWITCH_ERROR) break;
      if (bus.SELECT_REQ == 4'b1000) n_raise++;
    end
    check("to_cycles", n_raise, 20);
    check("to_err",    bus.SWITCH_ERROR, 1'b1);
    check("to_ready",  bus.SEL_READY,    1'b0);
    check("to_req",    bus.SELECT_REQ,   4'b1000);
    bus.ERROR_CLEAR = 1'b1;
    tick();
    bus.ERROR_CLEAR = 1'b0;
    check("to_clr_err",   bus.SWITCH_ERROR, 1'b0);
    check("to_clr_ready", bus.SEL_READY,    1'b1);
    check("to_clr_cur",   bus.CURRENT_SEL,  2'd2);
    stuck_off = 4'b0000;
    repeat (5) tick();
    switch_timed(3, t_on, t_done, n_done);
    check("reissue_done", t_done, 7);
    check("reissue_cur",  bus.CURRENT_SEL, 2'd3);

    // Reset while dropping, then a normal switch to 3.
    dly = 5;
    repeat (8) tick();
    bus.SEL_VALID = 1'b1; bus.SEL_ID = 3'd0;
    repeat (3) begin tick(); bus.SEL_VALID = 1'b0; end
    rst = 1'b1;
    #1;
    check("mid_rst_req",  bus.SELECT_REQ,   4'b0001);
    check("mid_rst_cur",  bus.CURRENT_SEL,  2'd0);
    check("mid_rst_done", bus.SWITCH_DONE,  1'b0);
    check("mid_rst_err",  bus.SWITCH_ERROR, 1'b0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    switch_timed(3, t_on, t_done, n_done);
    check("post_rst_done", t_done, 17);
    check("post_rst_cur",  bus.CURRENT_SEL, 2'd3);

    // Randomized traffic with stalls, clears and occasional resets.
    stuck_left = 0;
    for (int c = 0; c < 2500; c++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      if ($urandom_range(0, 99) == 0) dly = $urandom_range(0, 6);
      if (stuck_left > 0) begin
        stuck_left--;
        if (stuck_left == 0) begin stuck_on = 4'b0000; stuck_off = 4'b0000; end
      end else if ($urandom_range(0, 199) == 0) begin
        stuck_left = $urandom_range(25, 60);
        if ($urandom_range(0, 1) == 1) stuck_off = 4'b0001 << $urandom_range(0, 3);
        else stuck_on = 4'b0001 << $urandom_range(0, 3);
      end
      bus.SEL_VALID   = ($urandom_range(0, 3) == 0);
      bus.SEL_ID      = 3'($urandom_range(0, 5));
      bus.ERROR_CLEAR = ($urandom_range(0, 15) == 0);
    end
    bus.SEL_VALID = 1'b0;
    bus.ERROR_CLEAR = 1'b0;
    rst = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
